// File: rtl/cell_sample_framer.sv
// ============================================================================
// cell_sample_framer
// ----------------------------------------------------------------------------
// Collects per-cell voltage samples from the multiplexed cell ADC. Each
// unsigned sample is converted to IEEE 754 single precision, and one complete
// frame of N_CELLS words is buffered for the downstream 4-input floating-point
// pack-voltage summing stage. The frame is handed over with a valid/ready
// handshake. Samples must arrive in strict channel order (0,1,2,3). Any
// out-of-order sample abandons the partial frame and pulses frame_err.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous, active-high reset
//   adc_valid    in   ADC sample present
//   adc_data     in   unsigned sample code, ADC_BITS wide
//   adc_ch       in   cell index of the sample (2 bits)
//   adc_ready    out  framer can accept a sample this cycle
//   frame_valid  out  complete frame available
//   frame_ready  in   downstream consumes the frame
//   frame_data   out  cell i float at bits [32*i+31:32*i]
//   frame_err    out  one-cycle pulse on a channel-order violation
//
// Parameters:
//   N_CELLS   cells per frame, fixed at 4 to match the summing stage
//   ADC_BITS  sample width, 1..24, so every code converts exactly
// ============================================================================
module cell_sample_framer #(
    parameter int N_CELLS  = 4,
    parameter int ADC_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adc_valid,
    input  logic [ADC_BITS-1:0]    adc_data,
    input  logic [1:0]             adc_ch,
    output logic                   adc_ready,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [32*N_CELLS-1:0]  frame_data,
    output logic                   frame_err
);

    localparam logic [1:0] LAST_CH = 2'(N_CELLS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONV    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             exp_ch;
    logic [1:0]             exp_ch_next;
    logic [ADC_BITS-1:0]    cap_data;
    logic [1:0]             cap_ch;
    logic                   capture;
    logic                   slot_we;
    logic [1:0]             slot_idx;
    logic                   err_next;
    logic [31:0]            conv_word;
    logic [32*N_CELLS-1:0]  frame_q;
    logic                   err_q;

    // Unsigned integer to float. The sample is widened to 24 bits and the
    // leading one is shifted up to bit 23, which is the hidden bit. The 23
    // bits below it are then the mantissa, already left-justified and
    // zero-filled. The ADC is never wider than 24 bits, so no bit is lost
    // and no rounding is needed.
    function automatic logic [31:0] to_float(input logic [ADC_BITS-1:0] s);
        logic [23:0] ext;
        logic [23:0] norm;
        logic [4:0]  p;
        logic [7:0]  expo;
        ext = 24'(s);
        p   = '0;
        for (int i = 0; i < 24; i++) begin
            if (ext[i]) begin
                p = 5'(i);
            end
        end
        norm = ext << (5'd23 - p);
        expo = 8'd127 + 8'(p);
        if (ext == '0) begin
            return 32'h0000_0000;
        end
        return {1'b0, expo, norm[22:0]};
    endfunction

    assign conv_word = to_float(cap_data);

    // State register, expected-channel tracker and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COLLECT;
            exp_ch <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            exp_ch <= exp_ch_next;
            err_q  <= err_next;
        end
    end

    // Sample capture and frame slot storage. Slots are only ever overwritten,
    // never cleared outside reset. A frame abandoned part-way therefore
    // leaves stale words behind. Every slot is rewritten before the next
    // frame can be presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data <= '0;
            cap_ch   <= '0;
            frame_q  <= '0;
        end else begin
            if (capture) begin
                cap_data <= adc_data;
                cap_ch   <= adc_ch;
            end
            if (slot_we) begin
                frame_q[32*slot_idx +: 32] <= conv_word;
            end
        end
    end

    // Next-state logic. CONV always lasts exactly one cycle. During CONV the
    // captured channel is compared with the expected one. A stray channel 0
    // is treated as the start of a fresh frame rather than thrown away, so
    // the ADC can resynchronise without losing a sample.
    always_comb begin
        state_next  = state;
        exp_ch_next = exp_ch;
        capture     = 1'b0;
        slot_we     = 1'b0;
        slot_idx    = exp_ch;
        err_next    = 1'b0;
        case (state)
            COLLECT: begin
                if (adc_valid) begin
                    capture    = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cap_ch == exp_ch) begin
                    slot_we  = 1'b1;
                    slot_idx = exp_ch;
                    if (exp_ch == LAST_CH) begin
                        exp_ch_next = '0;
                        state_next  = PRESENT;
                    end else begin
                        exp_ch_next = exp_ch + 2'd1;
                        state_next  = COLLECT;
                    end
                end else begin
                    err_next   = 1'b1;
                    state_next = COLLECT;
                    if (cap_ch == 2'd0) begin
                        slot_we     = 1'b1;
                        slot_idx    = 2'd0;
                        exp_ch_next = 2'd1;
                    end else begin
                        exp_ch_next = 2'd0;
                    end
                end
            end
            PRESENT: begin
                if (frame_ready) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next  = COLLECT;
                exp_ch_next = '0;
            end
        endcase
    end

    assign adc_ready   = (state == COLLECT);
    assign frame_valid = (state == PRESENT);
    assign frame_data  = frame_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_cell_sample_framer.sv
// ============================================================================
// tb_cell_sample_framer
// ----------------------------------------------------------------------------
// Directed bench for cell_sample_framer. Each scenario task drives its own
// samples and compares the outputs against hand-computed float words.
// Inputs change 1 ns after a rising edge. Outputs are read at that same
// point, after the edge has settled.
// ============================================================================
module tb_cell_sample_framer;

    logic         clk;
    logic         rst;
    logic         adc_valid;
    logic [15:0]  adc_data;
    logic [1:0]   adc_ch;
    logic         adc_ready;
    logic         frame_valid;
    logic         frame_ready;
    logic [127:0] frame_data;
    logic         frame_err;

    int assertions;
    int failures;
    int cyc;
    int err_pulses;
    int valid_cycles;

    cell_sample_framer #(
        .N_CELLS  (4),
        .ADC_BITS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .adc_ch      (adc_ch),
        .adc_ready   (adc_ready),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Count high cycles of the two pulse-like outputs mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (frame_valid === 1'b1) valid_cycles++;
    end

    // Offer one sample and hold it until the framer accepts it. The task
    // returns 1 ns after the accepting edge, with the framer in CONV.
    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        int n;
        adc_ch    = ch;
        adc_data  = d;
        adc_valid = 1'b1;
        n = 0;
        while (adc_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            assertions++;
            failures++;
            $display("[TB] FAIL send_timeout: adc_ready=%b after %0d cycles, required 1", adc_ready, n);
        end
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adc_valid = 1'b1;
        adc_ch = 2'd0;
        adc_data = 16'h1234;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (adc_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_adc_ready: got %b, required 1", adc_ready);
        end
        assertions++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_frame_valid: got %b, required 0", frame_valid);
        end
        assertions++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_frame_err: got %b, required 0", frame_err);
        end
        assertions++;
        if (frame_data !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_frame_data: got %h, required 0", frame_data);
        end
        adc_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        logic [31:0] exp_w [4];
        int first_cyc;
        int e0;
        int v0;
        exp_w = '{32'h3F80_0000, 32'h454E_4000, 32'h477F_FF00, 32'h4700_0000};
        e0 = err_pulses;
        v0 = valid_cycles;
        frame_ready = 1'b1;
        send(2'd0, 16'h0001);
        first_cyc = cyc;
        send(2'd1, 16'h0CE4);
        send(2'd2, 16'hFFFF);
        send(2'd3, 16'h8000);
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_frame_valid: got %b, required 1", frame_valid);
        end
        assertions++;
        if (cyc - first_cyc != 7) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d cycles, required 7", cyc - first_cyc);
        end
        assertions++;
        if (adc_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_adc_ready_present: got %b, required 0", adc_ready);
        end
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (frame_data[32*i +: 32] !== exp_w[i]) begin
                failures++;
                $display("[TB] FAIL basic_word%0d: got %h, required %h", i, frame_data[32*i +: 32], exp_w[i]);
            end
        end
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b0 || adc_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_handshake: valid=%b ready=%b, required valid=0 ready=1", frame_valid, adc_ready);
        end
        assertions++;
        if (frame_data[31:0] !== 32'h3F80_0000) begin
            failures++;
            $display("[TB] FAIL basic_data_kept: got %h, required 3f800000", frame_data[31:0]);
        end
        assertions++;
        if (valid_cycles - v0 != 1) begin
            failures++;
            $display("[TB] FAIL basic_valid_cycles: got %0d, required 1", valid_cycles - v0);
        end
        assertions++;
        if (err_pulses - e0 != 0) begin
            failures++;
            $display("[TB] FAIL basic_no_err: got %0d pulses, required 0", err_pulses - e0);
        end
    endtask

    task automatic test_zero_samples();
        frame_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            send(2'(c), 16'h0000);
        end
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_frame_valid: got %b, required 1", frame_valid);
        end
        assertions++;
        if (frame_data !== 128'h0) begin
            failures++;
            $display("[TB] FAIL zero_frame_data: got %h, required 0", frame_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_skip_channel();
        logic [31:0] exp_w [4];
        int v0;
        int e0;
        exp_w = '{32'h4040_0000, 32'h4180_0000, 32'h437F_0000, 32'h4591_A000};
        frame_ready = 1'b1;
        v0 = valid_cycles;
        e0 = err_pulses;
        send(2'd0, 16'h0100);
        send(2'd1, 16'h0200);
        send(2'd3, 16'h0300);
        @(posedge clk); #1;
        assertions++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL skip_err_pulse: got %b, required 1", frame_err);
        end
        @(posedge clk); #1;
        assertions++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL skip_err_width: got %b, required 0", frame_err);
        end
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (valid_cycles - v0 != 0 || err_pulses - e0 != 1) begin
            failures++;
            $display("[TB] FAIL skip_counts: valid=%0d err=%0d, required valid=0 err=1", valid_cycles - v0, err_pulses - e0);
        end
        send(2'd0, 16'h0003);
        send(2'd1, 16'h0010);
        send(2'd2, 16'h00FF);
        send(2'd3, 16'h1234);
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL skip_recover_valid: got %b, required 1", frame_valid);
        end
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (frame_data[32*i +: 32] !== exp_w[i]) begin
                failures++;
                $display("[TB] FAIL skip_recover_word%0d: got %h, required %h", i, frame_data[32*i +: 32], exp_w[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ch0();
        logic [31:0] exp_w [4];
        int e0;
        exp_w = '{32'h4000_0000, 32'h3F80_0000, 32'h4700_0000, 32'h477F_FF00};
        frame_ready = 1'b1;
        e0 = err_pulses;
        send(2'd0, 16'h0005);
        send(2'd1, 16'h0006);
        send(2'd0, 16'h0002);
        @(posedge clk); #1;
        assertions++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_err_pulse: got %b, required 1", frame_err);
        end
        send(2'd1, 16'h0001);
        send(2'd2, 16'h8000);
        send(2'd3, 16'hFFFF);
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_frame_valid: got %b, required 1", frame_valid);
        end
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (frame_data[32*i +: 32] !== exp_w[i]) begin
                failures++;
                $display("[TB] FAIL restart_word%0d: got %h, required %h", i, frame_data[32*i +: 32], exp_w[i]);
            end
        end
        assertions++;
        if (err_pulses - e0 != 1) begin
            failures++;
            $display("[TB] FAIL restart_err_count: got %0d, required 1", err_pulses - e0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_frame;
        int e0;
        exp_frame = {32'h4700_0000, 32'h477F_FF00, 32'h454E_4000, 32'h3F80_0000};
        e0 = err_pulses;
        frame_ready = 1'b0;
        send(2'd0, 16'h0001);
        send(2'd1, 16'h0CE4);
        send(2'd2, 16'hFFFF);
        send(2'd3, 16'h8000);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            adc_valid = i[0];
            adc_ch    = 2'd2;
            adc_data  = 16'h7777;
            @(posedge clk); #1;
            assertions++;
            if (frame_valid !== 1'b1 || adc_ready !== 1'b0 || frame_data !== exp_frame) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b ready=%b data=%h, required valid=1 ready=0 data=%h",
                         i, frame_valid, adc_ready, frame_data, exp_frame);
            end
        end
        adc_valid   = 1'b0;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b0 || adc_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_release: valid=%b ready=%b, required valid=0 ready=1", frame_valid, adc_ready);
        end
        assertions++;
        if (err_pulses - e0 != 0) begin
            failures++;
            $display("[TB] FAIL hold_ignored_samples: got %0d err pulses, required 0", err_pulses - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp_w [4];
        exp_w = '{32'h3F80_0000, 32'h454E_4000, 32'h477F_FF00, 32'h4700_0000};
        frame_ready = 1'b1;
        send(2'd0, 16'h0003);
        send(2'd1, 16'h0010);
        send(2'd2, 16'h00FF);
        #2;
        rst = 1'b1;
        #1;
        assertions++;
        if (adc_ready !== 1'b1 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset_ctrl: ready=%b valid=%b err=%b, required 1/0/0", adc_ready, frame_valid, frame_err);
        end
        assertions++;
        if (frame_data !== 128'h0) begin
            failures++;
            $display("[TB] FAIL async_reset_data: got %h, required 0", frame_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(2'd0, 16'h0001);
        send(2'd1, 16'h0CE4);
        send(2'd2, 16'hFFFF);
        send(2'd3, 16'h8000);
        @(posedge clk); #1;
        assertions++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL after_reset_valid: got %b, required 1", frame_valid);
        end
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (frame_data[32*i +: 32] !== exp_w[i]) begin
                failures++;
                $display("[TB] FAIL after_reset_word%0d: got %h, required %h", i, frame_data[32*i +: 32], exp_w[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        assertions   = 0;
        failures     = 0;
        cyc          = 0;
        err_pulses   = 0;
        valid_cycles = 0;
        rst          = 1'b1;
        adc_valid    = 1'b0;
        adc_data     = '0;
        adc_ch       = '0;
        frame_ready  = 1'b0;
        test_reset();
        test_basic_frame();
        test_zero_samples();
        test_skip_channel();
        test_restart_ch0();
        test_backpressure();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/cell_sample_framer.md
# cell_sample_framer

Collects per-cell voltage samples from the multiplexed cell ADC, converts each unsigned integer sample to IEEE 754 single precision, and buffers one complete frame of N_CELLS words. It sits directly upstream of the 4-input floating-point pack-voltage summing stage and presents the frame with a valid/ready handshake. It also enforces strict channel ordering and flags out-of-order samples.

## Interface
- N_CELLS, 4: cells per frame. Fixed at 4 to match the summing stage. Channel field width is 2.
- ADC_BITS, 16: ADC sample width. Legal range 1..24, so conversion is exact.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- adc_valid  input  1  ADC sample present.
- adc_data  input  ADC_BITS  unsigned sample code.
- adc_ch  input  2  cell index of the sample.
- adc_ready  output  1  framer can accept a sample this cycle.
- frame_valid  output  1  complete frame available.
- frame_ready  input  1  downstream consumes the frame.
- frame_data  output  32*N_CELLS  cell i float at bits [32*i+31:32*i].
- frame_err  output  1  one-cycle pulse on a channel-order violation.

## Operation
- State machine with three states:
  - COLLECT: adc_ready=1.
  - CONV: adc_ready=0, converting the captured sample.
  - PRESENT: adc_ready=0, frame_valid=1.
- Reset (asynchronous):
  - State enters COLLECT; expected index exp_ch=0.
  - frame_data=0, frame_valid=0, frame_err=0, adc_ready=1.
  - Samples presented while rst=1 are ignored.
- Accept rule: a sample is accepted when adc_valid && adc_ready in COLLECT.
  - The framer registers adc_data and adc_ch, then moves to CONV.
- Channel check, performed in CONV:
  - adc_ch == exp_ch: the float is written to slot exp_ch.
    - If exp_ch == N_CELLS-1, go to PRESENT and reset exp_ch to 0.
    - Otherwise increment exp_ch and return to COLLECT.
  - adc_ch != exp_ch: the partial frame is abandoned and frame_err pulses for the CONV cycle.
    - If adc_ch == 0, the sample is written to slot 0, exp_ch=1, return to COLLECT.
    - Otherwise the sample is discarded, exp_ch=0, return to COLLECT.
  - Slots of an abandoned frame keep stale data. They are overwritten before the next frame_valid.
- Conversion (unsigned integer to float):
  - Sign bit is always 0.
  - Sample 0 produces 0x00000000.
  - Otherwise, with p = index of the most significant set bit:
    - exponent = 127 + p;
    - mantissa = sample bits below p, left-justified into 23 bits, zero-filled.
  - No rounding is needed because ADC_BITS ≤ 24.
- PRESENT:
  - frame_data and frame_valid are held stable until frame_ready=1.
  - On the handshake, return to COLLECT.
  - frame_data keeps its last value after the handshake and is not cleared.
- Reset mid-frame or mid-PRESENT discards everything and returns to the reset state immediately.

## Timing
- Sample accepted at edge t:
  - CONV occupies the cycle t..t+1.
  - The slot write and state update occur at edge t+1.
  - adc_ready returns high at t+1 unless the frame is now complete.
- Throughput: at most one sample per 2 cycles.
- frame_valid rises at the edge after the CONV cycle of the slot-(N_CELLS-1) sample. With continuous valid input, that is 7 cycles after the first acceptance (4 samples × 2 cycles − 1).
- Handshake at edge h (frame_valid && frame_ready sampled high):
  - frame_valid falls at h.
  - adc_ready rises at h.
  - The first sample of the next frame can be accepted at h+1.
- frame_err is registered and high for exactly one cycle, starting at the edge after acceptance of the offending sample.
- frame_ready is ignored outside PRESENT. adc_valid is ignored outside COLLECT; the ADC must hold its sample until adc_ready.

## Test plan
- Reset, then ch0..3 with data 0x0001, 0x0CE4, 0xFFFF, 0x8000, frame_ready=1 -> frame_data words 0x3F800000, 0x454E4000, 0x477FFF00, 0x47000000; frame_valid high for 1 cycle; frame_err never pulses.
- Data 0x0000 on all channels -> all four words 0x00000000; frame_valid asserts normally.
- ch0, ch1, then ch3 (skip) -> frame_err pulses once and no frame is produced. A following full ch0..3 sequence yields a correct frame.
- ch0, ch1, then ch0 with data 0x0002 -> frame_err pulses; slot 0 = 0x40000000; exp_ch=1. Completing ch1..3 yields frame_valid.
- Complete a frame, hold frame_ready=0 for 10 cycles -> frame_data and frame_valid stable; adc_ready=0; adc_valid pulses ignored. Raise frame_ready -> frame_valid falls at the next edge.
- Assert rst during CONV of the ch2 sample -> all outputs return to reset values asynchronously. After release, a full ch0..3 frame is produced correctly.
